icapetwo_responder: RTL and testbench

//  Cycle-level, synthesizable model of the 7-series ICAPE2 configuration port:
//  the far end of the Wishbone-to-ICAPE2 bridge. Decodes the 32-bit word stream
//  on CSIB/RDWRB/I and serves a 32-entry config register file.

---
 rtl/icape_pkg.sv | 32 +++
 rtl/icape_bitswap.sv | 18 +
 rtl/icapetwo_responder.sv | 194 +++++++++++++++++++
 tb/tb_icapetwo_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icape_pkg.sv
// Shared constants and FSM state type for the ICAPE2 responder.
package icape_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned CNT_W    = 11;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [DATA_W-1:0] SYNC_WORD  = 32'hAA995566;
    localparam logic [DATA_W-1:0] NOOP_WORD  = 32'h20000000;
    localparam logic [DATA_W-1:0] DUMMY_WORD = 32'hFFFFFFFF;

    // Type-1 header: [31:29] type, [28:27] opcode, [17:13] register, [10:0] word count
    localparam logic [2:0] TYPE1  = 3'b001;
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;

    localparam logic [ADDR_W-1:0] REG_CMD    = 5'h04;
    localparam logic [ADDR_W-1:0] REG_IDCODE = 5'h0c;
    localparam logic [ADDR_W-1:0] REG_WBSTAR = 5'h10;

    localparam logic [4:0] CMD_DESYNC = 5'h0d;
    localparam logic [4:0] CMD_IPROG  = 5'h0f;

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        HDR    = 2'd1,
        WDATA  = 2'd2
    } state_e;

endpackage

// File: rtl/icape_bitswap.sv
// Reverses bit order inside each byte of a 32-bit word (ICAPE2 pin order <-> logical order).
module icape_bitswap
    import icape_pkg::*;
(
    input  logic [DATA_W-1:0] i_word,
    output logic [DATA_W-1:0] o_word_c
);

    always_comb begin
        o_word_c = '0;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                o_word_c[b*8 + i] = i_word[b*8 + 7 - i];
            end
        end
    end

endmodule

// File: rtl/icapetwo_responder.sv
// ICAPE2 stand-in: decodes the sync/type-1 packet stream, serves a 32-entry
// config register file, readback with fixed latency, DESYNC and IPROG.
module icapetwo_responder
    import icape_pkg::*;
#(
    parameter logic [DATA_W-1:0] IDCODE     = 32'h0362D093,
    parameter int unsigned       RD_LATENCY = 3
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_csib,
    input  logic              i_rdwrb,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_synced,
    output logic              o_iprog,
    output logic [DATA_W-1:0] o_iprog_addr,
    output logic              o_err
);

    localparam int unsigned      LAT_W   = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(RD_LATENCY);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [LAT_W-1:0]  rd_lat_q, rd_lat_d;
    logic              csib_q, csib_d;
    logic              rdwrb_q, rdwrb_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] iprog_addr_q, iprog_addr_d;
    logic              synced_q, synced_d;
    logic              iprog_q, iprog_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] w_c;
    logic [DATA_W-1:0] rd_word_c;
    logic [DATA_W-1:0] rd_swap_c;
    logic [LAT_W-1:0]  lat_inc_c;
    logic              abort_c;

    icape_bitswap u_wr_swap (
        .i_word   (i_data),
        .o_word_c (w_c)
    );

    icape_bitswap u_rd_swap (
        .i_word   (rd_word_c),
        .o_word_c (rd_swap_c)
    );

    assign rd_word_c = (rd_addr_q == REG_IDCODE) ? IDCODE : regs_q[rd_addr_q];
    assign lat_inc_c = (rd_lat_q == LAT_MAX) ? rd_lat_q : rd_lat_q + LAT_W'(1);
    // Direction flip while chip select stays low aborts the session
    assign abort_c   = !i_csib && !csib_q && (i_rdwrb != rdwrb_q);

    always_comb begin
        state_d      = state_q;
        regs_d       = regs_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        rd_lat_d     = rd_lat_q;
        csib_d       = i_csib;
        rdwrb_d      = i_rdwrb;
        data_d       = data_q;
        iprog_addr_d = iprog_addr_q;
        synced_d     = synced_q;
        iprog_d      = 1'b0;
        err_d        = err_q;

        if (abort_c) begin
            err_d    = 1'b1;
            state_d  = UNSYNC;
            synced_d = 1'b0;
            rd_cnt_d = '0;
            wr_cnt_d = '0;
            rd_lat_d = '0;
        end else if (i_csib) begin
            rd_lat_d = '0;
        end else if (!i_rdwrb) begin
            case (state_q)
                UNSYNC: begin
                    if (w_c == SYNC_WORD) begin
                        state_d  = HDR;
                        synced_d = 1'b1;
                    end
                end
                HDR: begin
                    if (w_c != NOOP_WORD && w_c != DUMMY_WORD) begin
                        if (w_c[31:29] != TYPE1) begin
                            err_d = 1'b1;
                        end else begin
                            case (w_c[28:27])
                                OP_RD: begin
                                    rd_addr_d = w_c[17:13];
                                    rd_cnt_d  = w_c[10:0];
                                end
                                OP_WR: begin
                                    if (w_c[10:0] != '0) begin
                                        wr_addr_d = w_c[17:13];
                                        wr_cnt_d  = w_c[10:0];
                                        state_d   = WDATA;
                                    end
                                end
                                OP_NOP: begin
                                end
                                default: err_d = 1'b1;
                            endcase
                        end
                    end
                end
                WDATA: begin
                    if (wr_addr_q != REG_IDCODE) begin
                        regs_d[wr_addr_q] = w_c;
                    end
                    if (wr_cnt_q != '0) begin
                        wr_cnt_d = wr_cnt_q - CNT_W'(1);
                    end
                    if (wr_cnt_q <= CNT_W'(1)) begin
                        state_d = HDR;
                    end
                    // Commands act after the data word itself has been stored
                    if (wr_addr_q == REG_CMD) begin
                        if (w_c[4:0] == CMD_DESYNC) begin
                            state_d  = UNSYNC;
                            synced_d = 1'b0;
                            wr_cnt_d = '0;
                        end
                        if (w_c[4:0] == CMD_IPROG) begin
                            iprog_d      = 1'b1;
                            iprog_addr_d = regs_q[REG_WBSTAR];
                        end
                    end
                end
                default: state_d = UNSYNC;
            endcase
        end else if (state_q != UNSYNC) begin
            rd_lat_d = lat_inc_c;
            if (lat_inc_c == LAT_MAX && rd_cnt_q != '0) begin
                data_d   = rd_swap_c;
                rd_cnt_d = rd_cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= UNSYNC;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            rd_lat_q     <= '0;
            csib_q       <= 1'b1;
            rdwrb_q      <= 1'b0;
            data_q       <= '0;
            iprog_addr_q <= '0;
            synced_q     <= 1'b0;
            iprog_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            regs_q       <= regs_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_lat_q     <= rd_lat_d;
            csib_q       <= csib_d;
            rdwrb_q      <= rdwrb_d;
            data_q       <= data_d;
            iprog_addr_q <= iprog_addr_d;
            synced_q     <= synced_d;
            iprog_q      <= iprog_d;
            err_q        <= err_d;
        end
    end

    assign o_data       = data_q;
    assign o_synced     = synced_q;
    assign o_iprog      = iprog_q;
    assign o_iprog_addr = iprog_addr_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_icapetwo_responder.sv
// Bench for icapetwo_responder: directed bridge scenarios plus random word streams
// compared every cycle against a behavioural model of the ICAPE2 protocol.
module tb_icapetwo_responder;

    localparam logic [31:0] IDCODE_V = 32'h0362D093;
    localparam logic [31:0] SYNC_V   = 32'hAA995566;
    localparam logic [31:0] NOOP_V   = 32'h20000000;
    localparam int          LAT_V    = 3;

    logic        clk;
    logic        i_reset_n;
    logic        i_csib;
    logic        i_rdwrb;
    logic [31:0] i_data;
    logic [31:0] o_data;
    logic        o_synced;
    logic        o_iprog;
    logic [31:0] o_iprog_addr;
    logic        o_err;

    int n_asserts = 0;
    int n_fail    = 0;

    // Behavioural model state
    int          m_phase;   // 0 waiting for sync, 1 expecting header, 2 taking write data
    logic [31:0] m_regs [32];
    int          m_rdaddr, m_rdcnt, m_rdlat, m_wraddr, m_wrcnt;
    logic        m_prev_cs, m_prev_rw;
    logic [31:0] m_odata, m_iprog_addr;
    logic        m_sync, m_iprog, m_err;

    icapetwo_responder #(
        .IDCODE     (IDCODE_V),
        .RD_LATENCY (LAT_V)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (i_reset_n),
        .i_csib       (i_csib),
        .i_rdwrb      (i_rdwrb),
        .i_data       (i_data),
        .o_data       (o_data),
        .o_synced     (o_synced),
        .o_iprog      (o_iprog),
        .o_iprog_addr (o_iprog_addr),
        .o_err        (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] bswap(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[(i / 8) * 8 + 7 - (i % 8)] = x[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".o_data"},       o_data,            m_odata);
        chk({tag, ".o_synced"},     32'(o_synced),     32'(m_sync));
        chk({tag, ".o_iprog"},      32'(o_iprog),      32'(m_iprog));
        chk({tag, ".o_iprog_addr"}, o_iprog_addr,      m_iprog_addr);
        chk({tag, ".o_err"},        32'(o_err),        32'(m_err));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_phase = 0; m_rdaddr = 0; m_rdcnt = 0; m_rdlat = 0; m_wraddr = 0; m_wrcnt = 0;
        m_prev_cs = 1'b1; m_prev_rw = 1'b0;
        m_odata = '0; m_iprog_addr = '0; m_sync = 1'b0; m_iprog = 1'b0; m_err = 1'b0;
    endtask

    // One clock of protocol behaviour; w is the logical (unswapped) word
    task automatic model_step(input logic cs, input logic rw, input logic [31:0] w);
        logic [31:0] old_wbstar;
        m_iprog = 1'b0;
        if (!cs && !m_prev_cs && rw != m_prev_rw) begin
            m_err = 1'b1; m_phase = 0; m_sync = 1'b0;
            m_rdcnt = 0; m_wrcnt = 0; m_rdlat = 0;
        end else if (cs) begin
            m_rdlat = 0;
        end else if (!rw) begin
            if (m_phase == 0) begin
                if (w == SYNC_V) begin m_phase = 1; m_sync = 1'b1; end
            end else if (m_phase == 1) begin
                if (w != NOOP_V && w != 32'hFFFFFFFF) begin
                    if (w[31:29] != 3'b001 || w[28:27] == 2'b11) begin
                        m_err = 1'b1;
                    end else if (w[28:27] == 2'b01) begin
                        m_rdaddr = int'(w[17:13]);
                        m_rdcnt  = int'(w[10:0]);
                    end else if (w[28:27] == 2'b10 && w[10:0] != 11'd0) begin
                        m_wraddr = int'(w[17:13]);
                        m_wrcnt  = int'(w[10:0]);
                        m_phase  = 2;
                    end
                end
            end else begin
                old_wbstar = m_regs[16];
                if (m_wraddr != 12) m_regs[m_wraddr] = w;
                m_wrcnt--;
                if (m_wrcnt == 0) m_phase = 1;
                if (m_wraddr == 4 && w[4:0] == 5'h0f) begin
                    m_iprog = 1'b1;
                    m_iprog_addr = old_wbstar;
                end
                if (m_wraddr == 4 && w[4:0] == 5'h0d) begin
                    m_phase = 0; m_sync = 1'b0; m_wrcnt = 0;
                end
            end
        end else if (m_phase != 0) begin
            if (m_rdlat < LAT_V) m_rdlat++;
            if (m_rdlat == LAT_V && m_rdcnt > 0) begin
                m_odata = bswap((m_rdaddr == 12) ? IDCODE_V : m_regs[m_rdaddr]);
                m_rdcnt--;
            end
        end
        m_prev_cs = cs;
        m_prev_rw = rw;
    endtask

    // Entered just after a rising edge; returns just after the next one
    task automatic cyc(input logic cs, input logic rw, input logic [31:0] word);
        i_csib  = cs;
        i_rdwrb = rw;
        i_data  = bswap(word);
        @(posedge clk);
        model_step(cs, rw, word);
        #1;
        chk_model("cyc");
    endtask

    task automatic wr(input logic [31:0] word);
        cyc(1'b0, 1'b0, word);
    endtask

    task automatic rd();
        cyc(1'b0, 1'b1, 32'h0);
    endtask

    task automatic idle();
        cyc(1'b1, i_rdwrb, 32'h0);
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        #1;
        chk("rst.o_data",       o_data,         32'h0);
        chk("rst.o_synced",     32'(o_synced),  32'h0);
        chk("rst.o_iprog",      32'(o_iprog),   32'h0);
        chk("rst.o_iprog_addr", o_iprog_addr,   32'h0);
        chk("rst.o_err",        32'(o_err),     32'h0);
        i_csib  = 1'b1;
        i_rdwrb = 1'b0;
        i_data  = '0;
        model_reset();
        @(posedge clk);
        #1;
        i_reset_n = 1'b1;
    endtask

    initial begin
        logic        cs, rw;
        logic [31:0] wd;
        int          r;

        i_reset_n = 1'b1;
        i_csib    = 1'b1;
        i_rdwrb   = 1'b0;
        i_data    = '0;
        model_reset();
        #2;
        do_reset();

        // Config writes before sync are ignored
        wr(32'h30020001); wr(32'h12345678);
        chk("presync.o_synced", 32'(o_synced), 32'h0);

        // Bridge write sequence: WBSTAR write then DESYNC
        wr(32'hFFFFFFFF); wr(NOOP_V); wr(SYNC_V);
        chk("bridge.synced_rise", 32'(o_synced), 32'h1);
        wr(NOOP_V); wr(NOOP_V); wr(32'h30020001); wr(32'h12345678);
        wr(NOOP_V); wr(NOOP_V); wr(32'h30008001); wr(32'h0000000D);
        chk("bridge.synced_fall", 32'(o_synced), 32'h0);
        wr(NOOP_V); wr(NOOP_V);
        idle();

        // Readback of WBSTAR, then IDCODE with latency check
        wr(SYNC_V); wr(32'h28020001); idle();
        rd(); rd(); rd();
        chk("rd.wbstar", o_data, bswap(32'h12345678));
        idle();
        wr(32'h28018001); idle();
        rd(); rd();
        chk("rd.idcode_early", o_data, bswap(32'h12345678));
        rd();
        chk("rd.idcode_3rd", o_data, bswap(IDCODE_V));
        rd();
        chk("rd.idcode_held", o_data, bswap(IDCODE_V));
        idle();

        // IPROG pulse carries the previously written WBSTAR
        wr(32'h30020001); wr(32'h00400000);
        wr(32'h30008001); wr(32'h0000000F);
        chk("iprog.pulse", 32'(o_iprog), 32'h1);
        chk("iprog.addr", o_iprog_addr, 32'h00400000);
        wr(NOOP_V);
        chk("iprog.one_cycle", 32'(o_iprog), 32'h0);

        // Abort by flipping direction under chip select, then resync
        wr(NOOP_V);
        rd();
        chk("abort.err", 32'(o_err), 32'h1);
        chk("abort.synced", 32'(o_synced), 32'h0);
        idle();
        wr(SYNC_V);
        chk("abort.resync", 32'(o_synced), 32'h1);
        chk("abort.err_sticky", 32'(o_err), 32'h1);

        // Reset mid write-data, then pre-sync words ignored and a fresh write works
        wr(32'h30020002); wr(32'h11111111);
        do_reset();
        wr(32'h30020001); wr(32'h12345678);
        chk("rst2.presync", 32'(o_synced), 32'h0);
        wr(SYNC_V); wr(32'h28020001); idle();
        rd(); rd(); rd();
        chk("rst2.wbstar_zero", o_data, 32'h0);
        idle();
        wr(32'h30020001); wr(32'hCAFEF00D); wr(32'h28020001); idle();
        rd(); rd(); rd();
        chk("rst2.fresh_write", o_data, bswap(32'hCAFEF00D));
        chk("rst2.no_err", 32'(o_err), 32'h0);
        idle();

        // Random word streams against the model
        for (int n = 0; n < 2500; n++) begin
            cs = ($urandom_range(0, 7) == 0);
            rw = i_rdwrb;
            if (cs ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0)) rw = ~rw;
            r = int'($urandom_range(0, 15));
            case (r)
                0, 1:    wd = SYNC_V;
                2:       wd = NOOP_V;
                3:       wd = 32'hFFFFFFFF;
                4, 5:    wd = {3'b001, 2'b10, 9'd0, 5'($urandom_range(0, 31)), 2'd0,
                               11'($urandom_range(0, 2))};
                6, 7:    wd = {3'b001, 2'b01, 9'd0, 5'($urandom_range(0, 31)), 2'd0,
                               11'($urandom_range(0, 3))};
                8:       wd = 32'h30008001;
                9:       wd = ($urandom_range(0, 1) == 0) ? 32'h0000000F : 32'h0000000D;
                10:      wd = 32'h48000001;
                11:      wd = {3'b001, 2'b11, 27'($urandom)};
                12:      wd = {3'b001, 2'b00, 27'($urandom)};
                default: wd = $urandom;
            endcase
            cyc(cs, rw, wd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
